conv_mdc_ctrl_fsm: RTL and testbench
====================================

// Module: conv_mdc_ctrl_fsm
// PURPOSE
//  Main sequencer of the conv_mdc HWPE. It sits between the control slave (register file)
//  and the datapath: streamers (src_V source, dst_V sink) and engine/kernel adapter.
//  Per tile iteration it arms both streams and starts the engine, then waits for compute and
//  write drain. It advances the tile offset and raises a done event after NB_ITER tiles.
// PARAMETERS
//  CNT_LEN         1024   max output count per tile; CNT_W = $clog2(CNT_LEN)+1
//  TIMEOUT_CYCLES  65535  watchdog limit (used only with CONV_MDC_FSM_TIMEOUT_EN)
// PORTS
//  clk_i            in   1      clock
//  rst_ni           in   1      async active-low reset
//  clear_i          in   1      sync soft clear, highest priority after reset
//  start_i          in   1      job start pulse from control slave
//  nb_iter_i        in   16     tile count (0 treated as 1); sampled in IDLE on start_i
//  tilestride_i     in   32     byte offset added per tile; sampled with nb_iter_i
//  cnt_limit_i      in   CNT_W  outputs per tile, forwarded to engine
//  src_ready_i      in   1      src_V source ready to accept req_start
//  dst_ready_i      in   1      dst_V sink ready to accept req_start
//  dst_done_i       in   1      dst_V sink finished its transfer (1-cycle pulse)
//  eng_done_i       in   1      engine reached cnt_limit (1-cycle pulse)
//  src_req_start_o  out  1      1-cycle start to src_V source
//  dst_req_start_o  out  1      1-cycle start to dst_V sink
//  eng_start_o      out  1      1-cycle start to engine/kernel adapter
//  eng_clear_o      out  1      engine clear, 1 cycle
//  eng_cnt_limit_o  out  CNT_W  registered copy of cnt_limit_i
//  tile_offs_o      out  32     current tile address offset
//  iter_idx_o       out  16     current tile index
//  busy_o           out  1      high in every state except IDLE
//  done_o           out  1      job-done event, 1 cycle
//  error_o          out  1      sticky watchdog error
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. The outputs are registered.
//  IDLE: on start_i, latch nb_iter (0->1), tilestride, cnt_limit. Clear iter_idx/tile_offs/error.
//        Go to START. start_i is ignored in every state other than IDLE.
//  START: wait for src_ready_i & dst_ready_i in the same cycle. Then pulse
//        src_req_start_o, dst_req_start_o, eng_start_o together in the next cycle. Go to COMPUTE.
//  COMPUTE: wait eng_done_i -> WAIT. A dst_done_i seen here is latched in dst_seen.
//        If eng_done_i and dst_done_i arrive in the same cycle, go to UPDATEIDX directly.
//  WAIT: when dst_done_i or dst_seen is set, clear dst_seen and go to UPDATEIDX.
//  UPDATEIDX (1 cycle): if iter_idx+1 == nb_iter -> TERMINATE.
//        Else iter_idx++, tile_offs += tilestride (mod 2^32, wraps silently), go to START.
//  TERMINATE (1 cycle): done_o=1, eng_clear_o=1, go to IDLE. busy_o drops on the IDLE cycle.
//  Latency: start_i to the first req_start pulses is 2 cycles if both streamers are ready.
//        The last dst_done_i to done_o is 2 cycles (WAIT->UPDATEIDX->TERMINATE).
//  clear_i: state->IDLE, counters/dst_seen/error->0, pulses suppressed, no done_o.
//        Async reset mid-job behaves the same as clear_i.
//  iter_idx never exceeds nb_iter-1. nb_iter=0xFFFF completes 65535 tiles without overflow.
// CONFIGURATION
//  CONV_MDC_FSM_TIMEOUT_EN defined: a 32-bit watchdog counts cycles in COMPUTE+WAIT.
//    The count resets on entry to START. At TIMEOUT_CYCLES, error_o is set (sticky until next start_i/clear_i).
//    The FSM then goes to TERMINATE, so done_o still pulses.
//  Macro undefined: no watchdog logic, error_o tied 0, FSM waits indefinitely.
// TESTING
//  T1 nb_iter=3, tilestride=0x100, streamers always ready -> 3x req_start triplets.
//     tile_offs 0,0x100,0x200; one done_o 2 cycles after the 3rd dst_done_i.
//  T2 nb_iter=0 -> exactly one tile run, one done_o, iter_idx stays 0.
//  T3 dst_ready_i low for 10 cycles in START -> no req_start pulses until it rises.
//     busy_o high throughout.
//  T4 eng_done_i and dst_done_i same cycle -> COMPUTE->UPDATEIDX, no hang in WAIT.
//     dst_done_i before eng_done_i -> latched, proceeds.
//  T5 clear_i asserted mid-COMPUTE of tile 2 -> IDLE next cycle, all outputs 0, no done_o.
//     A new start_i restarts from tile 0.
//  T6 (TIMEOUT_EN, TIMEOUT_CYCLES=100) withhold eng_done_i -> error_o=1 after 100 cycles.
//     done_o pulses; start_i clears error_o.

Source files
------------

// File: rtl/conv_mdc_ctrl_fsm.sv
// Tile sequencer of the conv_mdc HWPE: arms src/dst streams, starts the engine, tracks tiles.
// Optional cycle watchdog on COMPUTE/WAIT is enabled by defining CONV_MDC_FSM_TIMEOUT_EN.
module conv_mdc_ctrl_fsm #(
  parameter int unsigned  CNT_LEN        = 1024,
  parameter int unsigned  TIMEOUT_CYCLES = 65535,
  localparam int unsigned CNT_W          = $clog2(CNT_LEN) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [15:0]      nb_iter_i,
  input  logic [31:0]      tilestride_i,
  input  logic [CNT_W-1:0] cnt_limit_i,
  input  logic             src_ready_i,
  input  logic             dst_ready_i,
  input  logic             dst_done_i,
  input  logic             eng_done_i,
  output logic             src_req_start_o,
  output logic             dst_req_start_o,
  output logic             eng_start_o,
  output logic             eng_clear_o,
  output logic [CNT_W-1:0] eng_cnt_limit_o,
  output logic [31:0]      tile_offs_o,
  output logic [15:0]      iter_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StCompute,
    StWait,
    StUpdate,
    StTerminate
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      nb_iter_q, nb_iter_d;
  logic [31:0]      stride_q, stride_d;
  logic [CNT_W-1:0] cnt_limit_q, cnt_limit_d;
  logic [15:0]      iter_q, iter_d;
  logic [31:0]      offs_q, offs_d;
  logic             dst_seen_q, dst_seen_d;
  logic             error_q, error_d;
  logic             start_pulse_q, start_pulse_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             timeout;
  logic             last_tile;

`ifdef CONV_MDC_FSM_TIMEOUT_EN
  logic [31:0] wdt_q, wdt_d;

  // Counts cycles spent waiting on compute/drain; rearmed every time a tile is started.
  always_comb begin
    wdt_d = wdt_q;
    if (state_q == StStart) begin
      wdt_d = '0;
    end else if (state_q == StCompute || state_q == StWait) begin
      wdt_d = wdt_q + 32'd1;
    end
  end

  assign timeout = (state_q == StCompute || state_q == StWait) &&
                   (wdt_q >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt_q <= '0;
    end else if (clear_i) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Widened compare so nb_iter = 0xFFFF cannot wrap.
  assign last_tile = (({1'b0, iter_q} + 17'd1) == {1'b0, nb_iter_q});

  always_comb begin
    state_d       = state_q;
    nb_iter_d     = nb_iter_q;
    stride_d      = stride_q;
    cnt_limit_d   = cnt_limit_q;
    iter_d        = iter_q;
    offs_d        = offs_q;
    dst_seen_d    = dst_seen_q;
    error_d       = error_q;
    start_pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          nb_iter_d   = (nb_iter_i == 16'd0) ? 16'd1 : nb_iter_i;
          stride_d    = tilestride_i;
          cnt_limit_d = cnt_limit_i;
          iter_d      = '0;
          offs_d      = '0;
          dst_seen_d  = 1'b0;
          error_d     = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (src_ready_i && dst_ready_i) begin
          start_pulse_d = 1'b1;
          state_d       = StCompute;
        end
      end
      StCompute: begin
        if (eng_done_i && dst_done_i) begin
          dst_seen_d = 1'b0;
          state_d    = StUpdate;
        end else if (eng_done_i) begin
          state_d = StWait;
        end else begin
          if (dst_done_i) begin
            dst_seen_d = 1'b1;
          end
          if (timeout) begin
            error_d = 1'b1;
            state_d = StTerminate;
          end
        end
      end
      StWait: begin
        if (dst_done_i || dst_seen_q) begin
          dst_seen_d = 1'b0;
          state_d    = StUpdate;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = StTerminate;
        end
      end
      StUpdate: begin
        if (last_tile) begin
          state_d = StTerminate;
        end else begin
          iter_d  = iter_q + 16'd1;
          offs_d  = offs_q + stride_q;
          state_d = StStart;
        end
      end
      StTerminate: begin
        dst_seen_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered outputs are computed from the next state so they align with it.
    done_d = (state_d == StTerminate);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      nb_iter_q     <= '0;
      stride_q      <= '0;
      cnt_limit_q   <= '0;
      iter_q        <= '0;
      offs_q        <= '0;
      dst_seen_q    <= 1'b0;
      error_q       <= 1'b0;
      start_pulse_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else if (clear_i) begin
      state_q       <= StIdle;
      nb_iter_q     <= '0;
      stride_q      <= '0;
      cnt_limit_q   <= '0;
      iter_q        <= '0;
      offs_q        <= '0;
      dst_seen_q    <= 1'b0;
      error_q       <= 1'b0;
      start_pulse_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nb_iter_q     <= nb_iter_d;
      stride_q      <= stride_d;
      cnt_limit_q   <= cnt_limit_d;
      iter_q        <= iter_d;
      offs_q        <= offs_d;
      dst_seen_q    <= dst_seen_d;
      error_q       <= error_d;
      start_pulse_q <= start_pulse_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign src_req_start_o = start_pulse_q;
  assign dst_req_start_o = start_pulse_q;
  assign eng_start_o     = start_pulse_q;
  assign eng_clear_o     = done_q;
  assign eng_cnt_limit_o = cnt_limit_q;
  assign tile_offs_o     = offs_q;
  assign iter_idx_o      = iter_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;

  timeout_cfg_a: assert property (@(posedge clk_i) disable iff (!rst_ni) TIMEOUT_CYCLES != 0);
  iter_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_q |-> (iter_q < nb_iter_q));
  start_pulse_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    start_pulse_q |=> !start_pulse_q);
  done_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_q |=> !busy_q);

endmodule

// File: tb/tb_conv_mdc_ctrl_fsm.sv
// Scoreboard bench for conv_mdc_ctrl_fsm: stimulus queues expected start/done events,
// a negedge monitor pops and checks them whenever the DUT pulses.
module tb_conv_mdc_ctrl_fsm;

  localparam int unsigned CntW = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [15:0]     nb_iter_i = '0;
  logic [31:0]     tilestride_i = '0;
  logic [CntW-1:0] cnt_limit_i = '0;
  logic            src_ready_i = 1'b1;
  logic            dst_ready_i = 1'b1;
  logic            dst_done_i = 1'b0;
  logic            eng_done_i = 1'b0;
  logic            src_req_start_o, dst_req_start_o, eng_start_o, eng_clear_o;
  logic [CntW-1:0] eng_cnt_limit_o;
  logic [31:0]     tile_offs_o;
  logic [15:0]     iter_idx_o;
  logic            busy_o, done_o, error_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic            is_done;
    logic [31:0]     offs;
    logic [15:0]     idx;
    logic [CntW-1:0] lim;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  conv_mdc_ctrl_fsm #(
    .CNT_LEN       (1024),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .nb_iter_i      (nb_iter_i),
    .tilestride_i   (tilestride_i),
    .cnt_limit_i    (cnt_limit_i),
    .src_ready_i    (src_ready_i),
    .dst_ready_i    (dst_ready_i),
    .dst_done_i     (dst_done_i),
    .eng_done_i     (eng_done_i),
    .src_req_start_o(src_req_start_o),
    .dst_req_start_o(dst_req_start_o),
    .eng_start_o    (eng_start_o),
    .eng_clear_o    (eng_clear_o),
    .eng_cnt_limit_o(eng_cnt_limit_o),
    .tile_offs_o    (tile_offs_o),
    .iter_idx_o     (iter_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] offs, input logic [15:0] idx,
                          input logic [CntW-1:0] lim);
    ev_t e;
    e = '{is_done: 1'b0, offs: offs, idx: idx, lim: lim};
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [15:0] idx);
    ev_t e;
    e = '{is_done: 1'b1, offs: '0, idx: idx, lim: '0};
    exp_q.push_back(e);
  endtask

  // Monitor: every start triplet or done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (src_req_start_o === 1'b1 || dst_req_start_o === 1'b1 ||
                           eng_start_o === 1'b1 || done_o === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: actual req=%b done=%b required no event",
                 src_req_start_o, done_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done) begin
          chk("done_pulse", {61'd0, done_o, eng_clear_o, busy_o}, 64'h7);
          chk("done_no_req", {61'd0, src_req_start_o, dst_req_start_o, eng_start_o}, 64'h0);
          chk("done_iter_idx", 64'(iter_idx_o), 64'(mon_e.idx));
        end else begin
          chk("req_triplet", {60'd0, src_req_start_o, dst_req_start_o, eng_start_o, done_o},
              64'he);
          chk("req_tile_offs", 64'(tile_offs_o), 64'(mon_e.offs));
          chk("req_iter_idx", 64'(iter_idx_o), 64'(mon_e.idx));
          chk("req_cnt_limit", 64'(eng_cnt_limit_o), 64'(mon_e.lim));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] nb, input logic [31:0] stride,
                           input logic [CntW-1:0] lim);
    nb_iter_i    = nb;
    tilestride_i = stride;
    cnt_limit_i  = lim;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (n < 50) begin
      step();
      n++;
      if (src_req_start_o) break;
    end
    chk({name, "_seen"}, 64'(src_req_start_o), 64'h1);
  endtask

  task automatic wait_done(input string name, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      step();
      n++;
      if (done_o) break;
    end
    chk({name, "_seen"}, 64'(done_o), 64'h1);
  endtask

  // Called right after the start-pulse edge; k counts cycles into COMPUTE.
  task automatic tile(input int eng_dly, input int dst_dly);
    int last;
    last = (eng_dly > dst_dly) ? eng_dly : dst_dly;
    for (int k = 0; k <= last; k++) begin
      eng_done_i = (k == eng_dly);
      dst_done_i = (k == dst_dly);
      step();
    end
    eng_done_i = 1'b0;
    dst_done_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    int bad_req;
    int bad_busy;
    int seen;

    // Reset
    step();
    step();
    chk("reset_outputs_in_reset", {57'd0, src_req_start_o, dst_req_start_o, eng_start_o,
        eng_clear_o, busy_o, done_o, error_o}, 64'h0);
    rst_n = 1'b1;
    step();
    chk("reset_outputs", {57'd0, src_req_start_o, dst_req_start_o, eng_start_o,
        eng_clear_o, busy_o, done_o, error_o}, 64'h0);
    chk("reset_offs_idx_lim", {5'd0, eng_cnt_limit_o, iter_idx_o, tile_offs_o}, 64'h0);

    // T1: three tiles, stride 0x100, spurious start_i mid-job ignored
    push_req(32'h0, 16'd0, 11'd10);
    push_req(32'h100, 16'd1, 11'd10);
    push_req(32'h200, 16'd2, 11'd10);
    push_done(16'd2);
    start_job(16'd3, 32'h100, 11'd10);
    chk("t1_busy_in_start", 64'(busy_o), 64'h1);
    wait_req("t1_req0", n);
    chk("t1_start_latency", 64'(n), 64'd1);
    tile(3, 5);
    wait_req("t1_req1", n);
    nb_iter_i    = 16'd7;
    tilestride_i = 32'hdead;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    tile(1, 4);
    wait_req("t1_req2", n);
    tile(4, 6);
    chk("t1_done_early", 64'(done_o), 64'h0);
    step();
    chk("t1_done_latency", 64'(done_o), 64'h1);
    chk("t1_error_clear", 64'(error_o), 64'h0);
    step();
    chk("t1_idle_after_done", {62'd0, busy_o, done_o}, 64'h0);

    // T2: nb_iter = 0 runs exactly one tile
    push_req(32'h0, 16'd0, 11'd5);
    push_done(16'd0);
    start_job(16'd0, 32'h80, 11'd5);
    wait_req("t2_req0", n);
    tile(2, 2);
    wait_done("t2_done", 20, n);
    chk("t2_done_latency", 64'(n), 64'd1);
    chk("t2_iter_idx", 64'(iter_idx_o), 64'h0);
    step();
    chk("t2_idle", 64'(busy_o), 64'h0);

    // T3: dst not ready holds off the start triplet
    dst_ready_i = 1'b0;
    push_req(32'h0, 16'd0, 11'd3);
    push_done(16'd0);
    start_job(16'd1, 32'h0, 11'd3);
    bad_req  = 0;
    bad_busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (src_req_start_o || dst_req_start_o || eng_start_o) bad_req++;
      if (!busy_o) bad_busy++;
      step();
    end
    chk("t3_no_req_while_stalled", 64'(bad_req), 64'h0);
    chk("t3_busy_while_stalled", 64'(bad_busy), 64'h0);
    dst_ready_i = 1'b1;
    step();
    chk("t3_req_after_ready", 64'(src_req_start_o), 64'h1);
    tile(0, 2);
    wait_done("t3_done", 20, n);
    step();

    // T4: same-cycle done, then dst_done before eng_done
    push_req(32'h0, 16'd0, 11'd7);
    push_req(32'h40, 16'd1, 11'd7);
    push_done(16'd1);
    start_job(16'd2, 32'h40, 11'd7);
    wait_req("t4_req0", n);
    tile(2, 2);
    wait_req("t4_req1", n);
    chk("t4_same_cycle_skip_wait", 64'(n), 64'd2);
    tile(4, 1);
    wait_done("t4_done", 20, n);
    chk("t4_latched_dst_latency", 64'(n), 64'd2);
    step();

    // T5: clear mid-COMPUTE of the second tile, then restart from tile 0
    push_req(32'h0, 16'd0, 11'd9);
    push_req(32'h10, 16'd1, 11'd9);
    start_job(16'd4, 32'h10, 11'd9);
    wait_req("t5_req0", n);
    tile(1, 2);
    wait_req("t5_req1", n);
    step();
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("t5_clear_flags", {57'd0, src_req_start_o, dst_req_start_o, eng_start_o,
        eng_clear_o, busy_o, done_o, error_o}, 64'h0);
    chk("t5_clear_offs_idx_lim", {5'd0, eng_cnt_limit_o, iter_idx_o, tile_offs_o}, 64'h0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o) seen++;
      step();
    end
    chk("t5_no_done_after_clear", 64'(seen), 64'h0);
    push_req(32'h0, 16'd0, 11'd9);
    push_req(32'h10, 16'd1, 11'd9);
    push_done(16'd1);
    start_job(16'd2, 32'h10, 11'd9);
    wait_req("t5_restart_req0", n);
    tile(0, 0);
    wait_req("t5_restart_req1", n);
    tile(1, 1);
    wait_done("t5_restart_done", 20, n);
    step();

    // T6: withheld eng_done
    push_req(32'h0, 16'd0, 11'd4);
`ifdef CONV_MDC_FSM_TIMEOUT_EN
    push_done(16'd0);
    start_job(16'd1, 32'h0, 11'd4);
    wait_req("t6_req0", n);
    wait_done("t6_timeout_done", 200, n);
    chk("t6_timeout_cycles", 64'(n), 64'd100);
    chk("t6_error_set", 64'(error_o), 64'h1);
    step();
    chk("t6_error_sticky_idle", {62'd0, error_o, busy_o}, 64'h2);
    push_req(32'h0, 16'd0, 11'd4);
    push_done(16'd0);
    start_job(16'd1, 32'h0, 11'd4);
    chk("t6_error_cleared_by_start", 64'(error_o), 64'h0);
    wait_req("t6_req1", n);
    tile(0, 0);
    wait_done("t6_done1", 20, n);
    step();
`else
    start_job(16'd1, 32'h0, 11'd4);
    wait_req("t6_req0", n);
    for (int i = 0; i < 150; i++) step();
    chk("t6_no_watchdog_error", 64'(error_o), 64'h0);
    chk("t6_still_waiting", {62'd0, busy_o, done_o}, 64'h2);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("t6_clear_idle", 64'(busy_o), 64'h0);
`endif

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
